// File: rtl/execute_stage_if.sv
// EX-stage bundle: E-side instruction fields, hazard controls and forwarding
// inputs flowing into execute_stage, plus the branch outputs and EX/MEM register
// outputs flowing back out. The hazard/decode side is the master.
interface execute_stage_if #(
    parameter int WIDTH = 32
);
    // Hazard-unit controls
    logic             stall_e;
    logic             flush_e;
    // Decoded instruction in EX
    logic             valid_e;
    logic             RegWriteE;
    logic             MemWriteE;
    logic [1:0]       ResultSrcE;
    logic             BranchE;
    logic             ALUSrcE;
    logic [2:0]       ALUControlE;
    logic [WIDTH-1:0] RD1_E;
    logic [WIDTH-1:0] RD2_E;
    logic [WIDTH-1:0] Imm_Ext_E;
    logic [WIDTH-1:0] PCE;
    logic [WIDTH-1:0] PCPlus4E;
    logic [4:0]       RD_E;
    // Forwarding
    logic [1:0]       ForwardA_E;
    logic [1:0]       ForwardB_E;
    logic [WIDTH-1:0] ResultW;
    // Same-cycle branch resolution
    logic             PCSrcE;
    logic [WIDTH-1:0] PCTargetE;
    // EX/MEM register
    logic             RegWriteM;
    logic             MemWriteM;
    logic             valid_m;
    logic [1:0]       ResultSrcM;
    logic [4:0]       RD_M;
    logic [WIDTH-1:0] ALU_ResultM;
    logic [WIDTH-1:0] WriteDataM;
    logic [WIDTH-1:0] PCPlus4M;

    modport master (
        output stall_e, flush_e, valid_e, RegWriteE, MemWriteE, ResultSrcE,
               BranchE, ALUSrcE, ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE,
               PCPlus4E, RD_E, ForwardA_E, ForwardB_E, ResultW,
        input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, valid_m, ResultSrcM,
               RD_M, ALU_ResultM, WriteDataM, PCPlus4M
    );

    modport slave (
        input  stall_e, flush_e, valid_e, RegWriteE, MemWriteE, ResultSrcE,
               BranchE, ALUSrcE, ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE,
               PCPlus4E, RD_E, ForwardA_E, ForwardB_E, ResultW,
        output PCSrcE, PCTargetE, RegWriteM, MemWriteM, valid_m, ResultSrcM,
               RD_M, ALU_ResultM, WriteDataM, PCPlus4M
    );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, beq resolution, branch target,
// and the EX/MEM pipeline register (priority rst > flush > stall > load).
module execute_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    execute_stage_if.slave   bus
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Select 11 is unused by the hazard unit and falls back to the register file.
    function automatic logic [WIDTH-1:0] fwd(input logic [1:0]       sel,
                                             input logic [WIDTH-1:0] rf_val,
                                             input logic [WIDTH-1:0] result_w,
                                             input logic [WIDTH-1:0] alu_m);
        case (sel)
            2'b01:   fwd = result_w;
            2'b10:   fwd = alu_m;
            default: fwd = rf_val;
        endcase
    endfunction

    logic             valid_m_q,       valid_m_d;
    logic             reg_write_m_q,   reg_write_m_d;
    logic             mem_write_m_q,   mem_write_m_d;
    logic [1:0]       result_src_m_q,  result_src_m_d;
    logic [4:0]       rd_m_q,          rd_m_d;
    logic [WIDTH-1:0] alu_result_m_q,  alu_result_m_d;
    logic [WIDTH-1:0] write_data_m_q,  write_data_m_d;
    logic [WIDTH-1:0] pc_plus4_m_q,    pc_plus4_m_d;

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] write_data_e;
    logic [WIDTH-1:0] alu_result_e;
    logic             zero_e;

    // Operand forwarding, ALU and branch decision (forward 10 reads the live EX/MEM value)
    always_comb begin
        src_a        = fwd(bus.ForwardA_E, bus.RD1_E, bus.ResultW, alu_result_m_q);
        write_data_e = fwd(bus.ForwardB_E, bus.RD2_E, bus.ResultW, alu_result_m_q);
        src_b        = bus.ALUSrcE ? bus.Imm_Ext_E : write_data_e;
        alu_result_e = '0;
        case (bus.ALUControlE)
            ALU_ADD: alu_result_e = src_a + src_b;
            ALU_SUB: alu_result_e = src_a - src_b;
            ALU_AND: alu_result_e = src_a & src_b;
            ALU_OR:  alu_result_e = src_a | src_b;
            ALU_SLT: alu_result_e = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_result_e = '0;
        endcase
        zero_e = (alu_result_e == '0);
    end

    assign bus.PCSrcE    = bus.valid_e & bus.BranchE & zero_e;
    assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;

    // EX/MEM next state: flush inserts a zeroed bubble, stall holds, otherwise load
    always_comb begin
        valid_m_d      = valid_m_q;
        reg_write_m_d  = reg_write_m_q;
        mem_write_m_d  = mem_write_m_q;
        result_src_m_d = result_src_m_q;
        rd_m_d         = rd_m_q;
        alu_result_m_d = alu_result_m_q;
        write_data_m_d = write_data_m_q;
        pc_plus4_m_d   = pc_plus4_m_q;
        if (bus.flush_e) begin
            valid_m_d      = 1'b0;
            reg_write_m_d  = 1'b0;
            mem_write_m_d  = 1'b0;
            result_src_m_d = '0;
            rd_m_d         = '0;
            alu_result_m_d = '0;
            write_data_m_d = '0;
            pc_plus4_m_d   = '0;
        end else if (!bus.stall_e) begin
            valid_m_d      = bus.valid_e;
            reg_write_m_d  = bus.RegWriteE & bus.valid_e;
            mem_write_m_d  = bus.MemWriteE & bus.valid_e;
            result_src_m_d = bus.ResultSrcE;
            rd_m_d         = bus.RD_E;
            alu_result_m_d = alu_result_e;
            write_data_m_d = write_data_e;
            pc_plus4_m_d   = bus.PCPlus4E;
        end
    end

    // EX/MEM register; reset discards the in-flight instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_m_q      <= 1'b0;
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            result_src_m_q <= '0;
            rd_m_q         <= '0;
            alu_result_m_q <= '0;
            write_data_m_q <= '0;
            pc_plus4_m_q   <= '0;
        end else begin
            valid_m_q      <= valid_m_d;
            reg_write_m_q  <= reg_write_m_d;
            mem_write_m_q  <= mem_write_m_d;
            result_src_m_q <= result_src_m_d;
            rd_m_q         <= rd_m_d;
            alu_result_m_q <= alu_result_m_d;
            write_data_m_q <= write_data_m_d;
            pc_plus4_m_q   <= pc_plus4_m_d;
        end
    end

    assign bus.valid_m     = valid_m_q;
    assign bus.RegWriteM   = reg_write_m_q;
    assign bus.MemWriteM   = mem_write_m_q;
    assign bus.ResultSrcM  = result_src_m_q;
    assign bus.RD_M        = rd_m_q;
    assign bus.ALU_ResultM = alu_result_m_q;
    assign bus.WriteDataM  = write_data_m_q;
    assign bus.PCPlus4M    = pc_plus4_m_q;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage RV32I pipeline, directly downstream of the ALU control decoder; consumes the 3-bit ALUControl it produces.
- Applies forwarding muxes to operands, executes the ALU op, resolves branches, computes the branch target, and registers results into the EX/MEM pipeline register.
- Hazard unit drives forward selects, stall and flush.

Parameters:
- WIDTH, 32: datapath width for operands, PC, results.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- stall_e  input  1  hold EX/MEM contents this cycle
- flush_e  input  1  load a bubble into EX/MEM this cycle
- valid_e  input  1  instruction in EX is real (not a bubble)
- RegWriteE  input  1  register-file write enable
- MemWriteE  input  1  data-memory write enable
- ResultSrcE  input  2  writeback select, passed through
- BranchE  input  1  instruction is beq
- ALUSrcE  input  1  0: operand B = forwarded RD2; 1: Imm_Ext_E
- ALUControlE  input  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RD1_E, RD2_E  input  WIDTH  register-file read data
- Imm_Ext_E  input  WIDTH  sign-extended immediate
- PCE, PCPlus4E  input  WIDTH  instruction PC and PC+4
- RD_E  input  5  destination register
- ForwardA_E, ForwardB_E  input  2  00: RD1/RD2; 01: ResultW; 10: ALU_ResultM; 11: treated as 00
- ResultW  input  WIDTH  writeback-stage result
- PCSrcE  output  1  branch taken (combinational)
- PCTargetE  output  WIDTH  PCE + Imm_Ext_E (combinational)
- RegWriteM, MemWriteM, valid_m  output  1  registered
- ResultSrcM  output  2  registered
- RD_M  output  5  registered
- ALU_ResultM, WriteDataM, PCPlus4M  output  WIDTH  registered

Behaviour:
- SrcA = fwd(ForwardA_E, RD1_E). WriteDataE = fwd(ForwardB_E, RD2_E). SrcB = ALUSrcE ? Imm_Ext_E : WriteDataE.
- ALU, all modulo 2^WIDTH:
  - add: SrcA + SrcB. sub: SrcA - SrcB. and, or: bitwise.
  - slt: signed compare; result 1 when SrcA < SrcB, else 0, zero-extended to WIDTH.
  - Undefined codes (100, 110, 111): result 0.
- ZeroE = (ALU result == 0). PCSrcE = valid_e & BranchE & ZeroE. A bubble never redirects the PC.
- PCTargetE = PCE + Imm_Ext_E, wrap on overflow.
- EX/MEM register updates on the rising clk edge. Priority is rst > flush_e > stall_e > load:
  - rst: every registered output becomes 0; valid_m = 0.
  - flush_e: valid_m, RegWriteM, MemWriteM = 0. Data fields are don't-care; implement as 0.
  - stall_e (no flush): all registered outputs hold their values.
  - Otherwise load the E-side values. valid_m = valid_e. RegWriteM = RegWriteE & valid_e. MemWriteM = MemWriteE & valid_e.
- Forward select 10 uses the current ALU_ResultM register value, including while stalled.
- Latency: 1 cycle from E inputs to M outputs. PCSrcE and PCTargetE are same-cycle combinational.
- Reset mid-operation discards the in-flight instruction. The first post-reset cycle presents a bubble to MEM.

Test Plan:
- Reset: rst=1 for 1 cycle with all inputs nonzero -> all M outputs 0 next edge, valid_m=0.
- Add with immediate: RD1=0x00000005, Imm=0xFFFFFFFE, ALUSrcE=1, ALUControl=000, RD_E=7 -> next edge ALU_ResultM=0x00000003, RD_M=7, RegWriteM=1.
- slt signed: SrcA=0xFFFFFFFF, SrcB=0x00000001, ALUControl=101 -> ALU_ResultM=1.
  - Swap operands -> ALU_ResultM=0.
- beq taken: RD1=RD2=0x10, BranchE=1, ALUControl=001, PCE=0x100, Imm=0x20 -> PCSrcE=1 and PCTargetE=0x120 same cycle.
  - Same stimulus with valid_e=0 -> PCSrcE=0.
- Forwarding: ALU_ResultM=0xAA, ResultW=0x55, ForwardA=10, ForwardB=01, ALUSrcE=0, ALUControl=011 -> ALU result 0xFF, WriteDataM=0x55.
- Stall/flush:
  - stall_e=1 for 2 cycles -> M outputs unchanged.
  - flush_e=1 and stall_e=1 together -> valid_m=0, RegWriteM=0, MemWriteM=0 (flush wins).
  - Release -> the next instruction loads normally.
